rf_hazard_ctrl: RTL and testbench

- Scheduler for the 32x32 register file in the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Tracks the destination tags of in-flight instructions in EX, MEM and WB.
- Decides, per ID-stage source operand, whether the RF read value is used or a later-stage result is forwarded.
- Stalls IF/ID and injects an EX bubble on load-use hazards, and on any RAW hazard when forwarding is disabled.

---
 rtl/rf_hazard_ctrl_pkg.sv | 57 +++++
 rtl/rf_hazard_ctrl_tag_match.sv | 25 ++
 rtl/rf_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_rf_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_hazard_ctrl_pkg.sv
// Shared types for the register-file hazard controller: forwarding-select
// encoding, tag-slot layouts and slot-match helpers.
package rf_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // Bit positions inside a match vector.
  localparam int unsigned M_EX  = 0;
  localparam int unsigned M_MEM = 1;
  localparam int unsigned M_WB  = 2;

  // EX slot keeps the load flag; once an instruction leaves EX its result is
  // always forwardable, so MEM/WB slots only carry what matching needs.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             ld;
  } tag_slot_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             we;
  } fwd_slot_t;

  localparam int unsigned FWD_SLOT_W = $bits(fwd_slot_t);

  function automatic fwd_slot_t fwd_view(input tag_slot_t s);
    fwd_slot_t f;
    f.v  = s.v;
    f.rd = s.rd;
    f.we = s.we;
    return f;
  endfunction

  function automatic logic slot_hit(input fwd_slot_t s, input logic [REG_W-1:0] r);
    return s.v && s.we && (s.rd == r) && (r != REG_ZERO);
  endfunction

  // Youngest producer wins.
  function automatic fwd_sel_e fwd_pick(input logic [2:0] m);
    if (m[M_EX])       return FWD_EX;
    else if (m[M_MEM]) return FWD_MEM;
    else if (m[M_WB])  return FWD_WB;
    else               return FWD_RF;
  endfunction

endpackage

// File: rtl/rf_hazard_ctrl_tag_match.sv
// rf_tag_match: compares one source register index against the EX, MEM and
// WB tag slots.
//   src      - source register index
//   ex_slot  - EX slot  {v, rd, we}
//   mem_slot - MEM slot {v, rd, we}
//   wb_slot  - WB slot  {v, rd, we}
//   match    - per-slot hit vector, bit M_EX/M_MEM/M_WB
module rf_tag_match
  import rf_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0]      src,
  input  logic [FWD_SLOT_W-1:0] ex_slot,
  input  logic [FWD_SLOT_W-1:0] mem_slot,
  input  logic [FWD_SLOT_W-1:0] wb_slot,
  output logic [2:0]            match
);

  always_comb begin
    match        = '0;
    match[M_EX]  = slot_hit(fwd_slot_t'(ex_slot), src);
    match[M_MEM] = slot_hit(fwd_slot_t'(mem_slot), src);
    match[M_WB]  = slot_hit(fwd_slot_t'(wb_slot), src);
  end

endmodule

// File: rtl/rf_hazard_ctrl.sv
// rf_hazard_ctrl: register-file hazard scheduler for the 5-stage pipeline.
// Tracks destination tags in EX/MEM/WB, selects per-operand forwarding, and
// stalls IF/ID with an EX bubble on load-use (or any RAW when FWD_EN=0).
//   clk, rst (sync, active-low), hold (global freeze), flush (kill ID)
//   id_*       - ID-stage instruction descriptor
//   stall      - freeze PC and IF/ID
//   ex_bubble  - load NOP into ID/EX
//   fwd_sel1/2 - operand source: 0 RF, 1 EX, 2 MEM, 3 WB
//   stall_cnt  - saturating count of un-held stall cycles
module rf_hazard_ctrl
  import rf_hazard_ctrl_pkg::*;
#(
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  output logic             stall,
  output logic             ex_bubble,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_cnt
);

  tag_slot_t        ex_slot_q,  ex_slot_d;
  fwd_slot_t        mem_slot_q, mem_slot_d;
  fwd_slot_t        wb_slot_q,  wb_slot_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [2:0] match1, match2;
  logic       ld_use, any_raw, raw_stall;
  fwd_sel_e   sel1, sel2;

  rf_tag_match u_match1 (
    .src      (id_rs1),
    .ex_slot  (fwd_view(ex_slot_q)),
    .mem_slot (mem_slot_q),
    .wb_slot  (wb_slot_q),
    .match    (match1)
  );

  rf_tag_match u_match2 (
    .src      (id_rs2),
    .ex_slot  (fwd_view(ex_slot_q)),
    .mem_slot (mem_slot_q),
    .wb_slot  (wb_slot_q),
    .match    (match2)
  );

  always_comb begin
    ld_use  = ex_slot_q.ld & ((id_rs1_used & match1[M_EX]) | (id_rs2_used & match2[M_EX]));
    any_raw = (id_rs1_used & (|match1)) | (id_rs2_used & (|match2));

    raw_stall = id_valid & (FWD_EN ? ld_use : any_raw);

    sel1 = FWD_RF;
    sel2 = FWD_RF;
    if (FWD_EN) begin
      if (id_rs1_used) sel1 = fwd_pick(match1);
      if (id_rs2_used) sel2 = fwd_pick(match2);
    end

    // flush discards the ID instruction, so its hazard is moot.
    stall     = raw_stall & ~flush;
    ex_bubble = (stall | flush) & ~hold;
    fwd_sel1  = sel1;
    fwd_sel2  = sel2;
  end

  always_comb begin
    ex_slot_d   = ex_slot_q;
    mem_slot_d  = mem_slot_q;
    wb_slot_d   = wb_slot_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      wb_slot_d  = mem_slot_q;
      mem_slot_d = fwd_view(ex_slot_q);
      if (stall || flush || !id_valid) begin
        ex_slot_d = '0;
      end else begin
        ex_slot_d.v  = 1'b1;
        ex_slot_d.rd = id_rd;
        ex_slot_d.we = id_we;
        ex_slot_d.ld = id_is_load;
      end
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_slot_q   <= '0;
      mem_slot_q  <= '0;
      wb_slot_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_slot_q   <= ex_slot_d;
      mem_slot_q  <= mem_slot_d;
      wb_slot_q   <= wb_slot_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// Self-checking bench for rf_hazard_ctrl: one instance with forwarding
// (32-bit counter) and one without forwarding (4-bit counter), each driven
// by directed steps followed by random stimulus, checked against a model
// that reasons in terms of instruction age since issue.
module tb_rf_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       hold;
    logic       flush;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       u1;
    logic       u2;
    logic [4:0] id_rd;
    logic       id_we;
    logic       id_is_load;
  } in_t;

  typedef struct packed {
    logic [31:0] t;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
  } ent_t;

  localparam logic [63:0] CAP_A = 64'hFFFF_FFFF;
  localparam logic [63:0] CAP_B = 64'd15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t ia, ib;

  logic        a_stall, a_bub, b_stall, b_bub;
  logic [1:0]  a_sel1, a_sel2, b_sel1, b_sel2;
  logic [31:0] a_cnt;
  logic [3:0]  b_cnt;

  rf_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(ia.rst), .hold(ia.hold), .flush(ia.flush),
    .id_valid(ia.id_valid), .id_rs1(ia.id_rs1), .id_rs2(ia.id_rs2),
    .id_rs1_used(ia.u1), .id_rs2_used(ia.u2), .id_rd(ia.id_rd),
    .id_we(ia.id_we), .id_is_load(ia.id_is_load),
    .stall(a_stall), .ex_bubble(a_bub), .fwd_sel1(a_sel1), .fwd_sel2(a_sel2),
    .stall_cnt(a_cnt)
  );

  rf_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(ib.rst), .hold(ib.hold), .flush(ib.flush),
    .id_valid(ib.id_valid), .id_rs1(ib.id_rs1), .id_rs2(ib.id_rs2),
    .id_rs1_used(ib.u1), .id_rs2_used(ib.u2), .id_rd(ib.id_rd),
    .id_we(ib.id_we), .id_is_load(ib.id_is_load),
    .stall(b_stall), .ex_bubble(b_bub), .fwd_sel1(b_sel1), .fwd_sel2(b_sel2),
    .stall_cnt(b_cnt)
  );

  // Model state: issued instructions with their issue time; pipeline time
  // advances only on un-held, non-reset cycles. Age 1/2/3 = EX/MEM/WB.
  ent_t        qa[$], qb[$];
  logic [31:0] ta, tb;
  logic [63:0] ca, cb;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic in_t ins(input logic v, input logic [4:0] r1, input logic u1,
                              input logic [4:0] r2, input logic u2,
                              input logic [4:0] rd, input logic we, input logic ld);
    in_t r;
    r.rst = 1'b1; r.hold = 1'b0; r.flush = 1'b0;
    r.id_valid = v; r.id_rs1 = r1; r.u1 = u1; r.id_rs2 = r2; r.u2 = u2;
    r.id_rd = rd; r.id_we = we; r.id_is_load = ld;
    return r;
  endfunction

  function automatic in_t rand_in();
    in_t r;
    r.rst        = ($urandom_range(0, 63) != 0);
    r.hold       = ($urandom_range(0, 9) == 0);
    r.flush      = ($urandom_range(0, 7) == 0);
    r.id_valid   = ($urandom_range(0, 4) != 0);
    r.id_rs1     = 5'($urandom_range(0, 5));
    r.id_rs2     = 5'($urandom_range(0, 5));
    r.u1         = 1'($urandom_range(0, 1));
    r.u2         = 1'($urandom_range(0, 1));
    r.id_rd      = 5'($urandom_range(0, 5));
    r.id_we      = ($urandom_range(0, 3) != 0);
    r.id_is_load = ($urandom_range(0, 2) == 0);
    return r;
  endfunction

  // Source for an operand is the age of the youngest in-flight writer of it.
  function automatic void predict(input ent_t q[$], input logic [31:0] now, input in_t in,
                                  input logic fwd_en, output logic st, output logic bub,
                                  output logic [1:0] s1, output logic [1:0] s2);
    int unsigned best1 = 0, best2 = 0, age;
    logic lu = 1'b0, raw, hit;
    foreach (q[i]) begin
      age = now - q[i].t;
      if (age >= 1 && age <= 3 && q[i].we && q[i].rd != 5'd0) begin
        if (q[i].rd == in.id_rs1 && (best1 == 0 || age < best1)) best1 = age;
        if (q[i].rd == in.id_rs2 && (best2 == 0 || age < best2)) best2 = age;
        if (age == 1 && q[i].ld &&
            ((in.u1 && q[i].rd == in.id_rs1) || (in.u2 && q[i].rd == in.id_rs2))) lu = 1'b1;
      end
    end
    hit = (in.u1 && best1 != 0) || (in.u2 && best2 != 0);
    raw = in.id_valid && (fwd_en ? lu : hit);
    s1  = (fwd_en && in.u1) ? best1[1:0] : 2'd0;
    s2  = (fwd_en && in.u2) ? best2[1:0] : 2'd0;
    st  = raw && !in.flush;
    bub = (st || in.flush) && !in.hold;
  endfunction

  task automatic step();
    logic sa, ba, sb, bb;
    logic [1:0] x1, x2, y1, y2;
    #1;
    predict(qa, ta, ia, 1'b1, sa, ba, x1, x2);
    predict(qb, tb, ib, 1'b0, sb, bb, y1, y2);
    chk("a_stall", a_stall, sa);   chk("a_bubble", a_bub, ba);
    chk("a_sel1", a_sel1, x1);     chk("a_sel2", a_sel2, x2);
    chk("a_cnt", a_cnt, ca);
    chk("b_stall", b_stall, sb);   chk("b_bubble", b_bub, bb);
    chk("b_sel1", b_sel1, y1);     chk("b_sel2", b_sel2, y2);
    chk("b_cnt", b_cnt, cb);
    @(posedge clk);
    if (!ia.rst) begin
      qa.delete(); ca = '0;
    end else if (!ia.hold) begin
      if (ia.id_valid && !sa && !ia.flush)
        qa.push_back('{t: ta, rd: ia.id_rd, we: ia.id_we, ld: ia.id_is_load});
      ta++;
      if (sa && ca != CAP_A) ca++;
      while (qa.size() > 0 && (ta - qa[0].t) > 3) void'(qa.pop_front());
    end
    if (!ib.rst) begin
      qb.delete(); cb = '0;
    end else if (!ib.hold) begin
      if (ib.id_valid && !sb && !ib.flush)
        qb.push_back('{t: tb, rd: ib.id_rd, we: ib.id_we, ld: ib.id_is_load});
      tb++;
      if (sb && cb != CAP_B) cb++;
      while (qb.size() > 0 && (tb - qb[0].t) > 3) void'(qb.pop_front());
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t nop;
    nop = ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ta = '0; tb = '0; ca = '0; cb = '0;

    // Reset for two cycles with a live reader of x5 in ID.
    ia = ins(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); ia.rst = 1'b0;
    ib = nop; ib.rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall", a_stall, 0); chk("rst_bubble", a_bub, 0);
    chk("rst_sel1", a_sel1, 0);   chk("rst_cnt", a_cnt, 0);
    chk("rst_cnt_b", b_cnt, 0);
    step();
    ib = nop;

    // EX / MEM / WB forwarding of x5.
    ia = ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); step();
    ia = ins(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    #1; chk("fwd_ex_sel1", a_sel1, 1); chk("fwd_ex_stall", a_stall, 0); step();
    ia = ins(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1; chk("fwd_mem_sel1", a_sel1, 2); step();
    #1; chk("fwd_wb_sel1", a_sel1, 3);  step();
    #1; chk("fwd_rf_sel1", a_sel1, 0);  step();

    // Load-use on rs2.
    ia = ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); step();
    ia = ins(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    #1; chk("lu_stall", a_stall, 1); chk("lu_bubble", a_bub, 1); step();
    #1; chk("lu_resolved", a_stall, 0); chk("lu_sel2", a_sel2, 2); chk("lu_cnt", a_cnt, 1); step();

    // x0 never forwards or stalls, even from a load.
    ia = ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); step();
    ia = ins(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    #1; chk("x0_sel1", a_sel1, 0); chk("x0_sel2", a_sel2, 0); chk("x0_stall", a_stall, 0); step();

    // Writers to x3 in EX and MEM: EX wins.
    ia = ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); step(); step();
    ia = ins(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
    #1; chk("prio_sel1", a_sel1, 1); chk("prio_sel2", a_sel2, 1); step();

    // Load-use with flush: no stall, bubble, no count.
    ia = ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); step();
    ia = ins(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); ia.flush = 1'b1;
    #1; chk("fl_stall", a_stall, 0); chk("fl_bubble", a_bub, 1); chk("fl_cnt", a_cnt, 1); step();
    ia = nop; step();

    // Load-use under hold for three cycles.
    ia = ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); step();
    ia = ins(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); ia.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("hold_stall", a_stall, 1); chk("hold_bubble", a_bub, 0); chk("hold_cnt", a_cnt, 1);
      step();
    end
    ia.hold = 1'b0;
    #1; chk("unhold_stall", a_stall, 1); chk("unhold_bubble", a_bub, 1); step();
    #1; chk("unhold_sel1", a_sel1, 2); chk("unhold_stall2", a_stall, 0); chk("unhold_cnt", a_cnt, 2);
    step();
    ia = nop;

    // No forwarding: RAW on EX writer stalls three cycles.
    ib = ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); step();
    ib = ins(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1; chk("nf_stall", b_stall, 1); chk("nf_sel1", b_sel1, 0); step();
    end
    #1; chk("nf_release", b_stall, 0); chk("nf_cnt", b_cnt, 3); step();

    // Saturate the 4-bit counter.
    for (int r = 0; r < 5; r++) begin
      ib = ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); step();
      ib = ins(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
      repeat (4) step();
    end
    ib = nop;
    #1; chk("sat_cnt", b_cnt, 15); step();

    // Random traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      ia = rand_in();
      ib = rand_in();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
